// File: rtl/cnn_conv_stream.sv
`default_nettype none
// ==========================================================================
// cnn_conv_stream : streaming KxK conv core (line buffers + 3-stage MAC pipe)
// Optional ReLU via `define CNN_CONV_STREAM_RELU_EN.   Rev 1.0
// ==========================================================================
module cnn_conv_stream #(
  parameter int IN_X   = 12,
  parameter int IN_Y   = 12,
  parameter int K      = 5,
  parameter int CI     = 3,
  parameter int CO     = 3,
  parameter int IBW    = 20,
  parameter int WBW    = 8,
  parameter int BBW    = 16,
  parameter int OSHIFT = 0,
  parameter int OBW    = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CO*CI*K*K*WBW-1:0] i_weight,
  input  logic [CO*BBW-1:0]        i_bias,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [CI*IBW-1:0]        i_fmap,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [CO*OBW-1:0]        o_fmap,
  output logic                     o_last
);

  localparam int NTAP   = CI * K * K;
  localparam int ACC_BW = IBW + WBW + $clog2(NTAP);
  localparam int SUM_BW = ((ACC_BW > BBW) ? ACC_BW : BBW) + 1;
  localparam int EBW    = (SUM_BW > OBW) ? SUM_BW : OBW;
  localparam int XW     = (IN_X > 1) ? $clog2(IN_X) : 1;
  localparam int YW     = (IN_Y > 1) ? $clog2(IN_Y) : 1;
  localparam int LBR    = (K > 1) ? K - 1 : 1;

  localparam logic [XW-1:0] C_X_LAST = XW'(IN_X - 1);
  localparam logic [YW-1:0] C_Y_LAST = YW'(IN_Y - 1);
  localparam logic [XW-1:0] C_X_WIN  = XW'(K - 1);
  localparam logic [YW-1:0] C_Y_WIN  = YW'(K - 1);
  localparam logic signed [EBW-1:0] C_OMAX = {{(EBW-OBW+1){1'b0}}, {(OBW-1){1'b1}}};
  localparam logic signed [EBW-1:0] C_OMIN = ~C_OMAX;

  logic                     w_ce;
  logic                     w_accept;
  logic                     w_win_pos;
  logic [XW-1:0]            r_col;
  logic [YW-1:0]            r_row;
  logic signed [IBW-1:0]    w_pix    [CI];
  logic signed [IBW-1:0]    w_col    [CI][K];
  logic signed [IBW-1:0]    r_lb     [CI][LBR][IN_X];
  logic signed [IBW-1:0]    r_win    [CI][K][K];
  logic                     r_win_valid;
  logic                     r_win_last;
  logic signed [IBW-1:0]    r_s1_win [CI][K][K];
  logic                     r_s1_valid;
  logic                     r_s1_last;
  logic signed [ACC_BW-1:0] w_acc    [CO];
  logic signed [ACC_BW-1:0] r_s2_acc [CO];
  logic                     r_s2_valid;
  logic                     r_s2_last;
  logic [CO*OBW-1:0]        w_res;

  // A stalled output freezes the whole core, including the input side.
  assign w_ce      = !(o_valid && !o_ready);
  assign i_ready   = w_ce;
  assign w_accept  = i_valid && w_ce;
  assign w_win_pos = (r_row >= C_Y_WIN) && (r_col >= C_X_WIN);

  always_comb begin
    for (int ci = 0; ci < CI; ci++) begin
      w_pix[ci] = i_fmap[ci*IBW +: IBW];
    end
  end

  // Vertical column of the window: stored rows (oldest first) then the live pixel.
  always_comb begin
    for (int ci = 0; ci < CI; ci++) begin
      for (int ky = 0; ky < K - 1; ky++) begin
        w_col[ci][ky] = r_lb[ci][ky][r_col];
      end
      w_col[ci][K-1] = w_pix[ci];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ci = 0; ci < CI; ci++)
        for (int r = 0; r < LBR; r++)
          for (int x = 0; x < IN_X; x++)
            r_lb[ci][r][x] <= '0;
    end else if (w_accept && (K > 1)) begin
      for (int ci = 0; ci < CI; ci++) begin
        for (int r = 0; r < K - 2; r++) begin
          r_lb[ci][r][r_col] <= r_lb[ci][r+1][r_col];
        end
        r_lb[ci][LBR-1][r_col] <= w_pix[ci];
      end
    end
  end

  always_comb begin
    logic signed [ACC_BW-1:0] w_a;
    logic signed [ACC_BW-1:0] w_b;
    w_a = '0;
    w_b = '0;
    for (int co = 0; co < CO; co++) begin
      w_acc[co] = '0;
      for (int ci = 0; ci < CI; ci++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            w_a = ACC_BW'(r_s1_win[ci][ky][kx]);
            w_b = ACC_BW'($signed(i_weight[(((co*CI+ci)*K+ky)*K+kx)*WBW +: WBW]));
            w_acc[co] = w_acc[co] + w_a * w_b;
          end
    end
  end

  always_comb begin
    logic signed [SUM_BW-1:0] w_sum;
    logic signed [EBW-1:0]    w_ext;
    w_res = '0;
    w_sum = '0;
    w_ext = '0;
    for (int co = 0; co < CO; co++) begin
      w_sum = SUM_BW'(r_s2_acc[co]) + SUM_BW'($signed(i_bias[co*BBW +: BBW]));
      w_ext = EBW'(w_sum >>> OSHIFT);
`ifdef CNN_CONV_STREAM_RELU_EN
      if (w_ext[EBW-1])         w_ext = '0;
      else if (w_ext > C_OMAX)  w_ext = C_OMAX;
`else
      if (w_ext > C_OMAX)       w_ext = C_OMAX;
      else if (w_ext < C_OMIN)  w_ext = C_OMIN;
`endif
      w_res[co*OBW +: OBW] = w_ext[OBW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_last   <= 1'b0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_fmap      <= '0;
      for (int ci = 0; ci < CI; ci++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            r_win[ci][ky][kx]    <= '0;
            r_s1_win[ci][ky][kx] <= '0;
          end
      for (int co = 0; co < CO; co++) r_s2_acc[co] <= '0;
    end else if (w_ce) begin
      if (w_accept) begin
        if (r_col == C_X_LAST) begin
          r_col <= '0;
          r_row <= (r_row == C_Y_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        // Horizontal shift: kx=K-1 takes the newest column.
        for (int ci = 0; ci < CI; ci++)
          for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K - 1; kx++) r_win[ci][ky][kx] <= r_win[ci][ky][kx+1];
            r_win[ci][ky][K-1] <= w_col[ci][ky];
          end
      end
      r_win_valid <= w_accept && w_win_pos;
      r_win_last  <= w_accept && (r_row == C_Y_LAST) && (r_col == C_X_LAST);

      for (int ci = 0; ci < CI; ci++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            r_s1_win[ci][ky][kx] <= r_win[ci][ky][kx];
      r_s1_valid <= r_win_valid;
      r_s1_last  <= r_win_last;

      for (int co = 0; co < CO; co++) r_s2_acc[co] <= w_acc[co];
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;

      o_valid <= r_s2_valid;
      o_last  <= r_s2_last;
      o_fmap  <= w_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_conv_stream.sv
`default_nettype none
// Bench for cnn_conv_stream: directed frames, convolution model feeding a scoreboard queue.
module tb_cnn_conv_stream;
  localparam int X = 6, Y = 6, KK = 3, NCI = 2, NCO = 2;
  localparam int IB = 12, WB = 8, BB = 16, OB = 12, OSH = 0;
  localparam int NW = NCO * NCI * KK * KK;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NW*WB-1:0]   i_weight = '0;
  logic [NCO*BB-1:0]  i_bias = '0;
  logic               i_valid = 1'b0;
  logic               i_ready;
  logic [NCI*IB-1:0]  i_fmap = '0;
  logic               o_valid;
  logic               o_ready = 1'b1;
  logic [NCO*OB-1:0]  o_fmap;
  logic               o_last;

  cnn_conv_stream #(
    .IN_X(X), .IN_Y(Y), .K(KK), .CI(NCI), .CO(NCO), .IBW(IB), .WBW(WB),
    .BBW(BB), .OSHIFT(OSH), .OBW(OB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_weight(i_weight), .i_bias(i_bias),
    .i_valid(i_valid), .i_ready(i_ready), .i_fmap(i_fmap),
    .o_valid(o_valid), .o_ready(o_ready), .o_fmap(o_fmap), .o_last(o_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCO*OB-1:0] fmap;
    logic              last;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   wt [NCO][NCI][KK][KK];
  int   bs [NCO];
  int   img [Y][X][NCI];
  int   mrow = 0, mcol = 0, outs = 0, lasts = 0, cyc = 0;
  int   first_win = -1, first_ov = -1;
  bit   lat_arm = 1'b0, rdy_rnd = 1'b0, prev_stall = 1'b0;
  logic [NCO*OB+1:0] prev_out = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int r, input int c);
    exp_t e;
    e.fmap = '0;
    for (int co = 0; co < NCO; co++) begin
      int v;
      v = bs[co];
      for (int ci = 0; ci < NCI; ci++)
        for (int ky = 0; ky < KK; ky++)
          for (int kx = 0; kx < KK; kx++)
            v += img[r-KK+1+ky][c-KK+1+kx][ci] * wt[co][ci][ky][kx];
      v = v >>> OSH;
`ifdef CNN_CONV_STREAM_RELU_EN
      if (v < 0) v = 0;
`endif
      if (v > (2**(OB-1)) - 1) v = (2**(OB-1)) - 1;
      if (v < -(2**(OB-1)))    v = -(2**(OB-1));
      e.fmap[co*OB +: OB] = OB'(v);
    end
    e.last = (r == Y-1) && (c == X-1);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset_n) begin
      check("valid_in_reset", 64'(o_valid), 64'd0);
      prev_stall = 1'b0;
    end else begin
      check("i_ready", 64'(i_ready), 64'(!(o_valid && !o_ready)));
      if (prev_stall) check("stall_hold", 64'({o_valid, o_last, o_fmap}), 64'(prev_out));
      if (i_valid && i_ready) begin
        for (int ci = 0; ci < NCI; ci++) img[mrow][mcol][ci] = $signed(i_fmap[ci*IB +: IB]);
        if (mrow >= KK-1 && mcol >= KK-1) begin
          q.push_back(model(mrow, mcol));
          if (lat_arm && first_win < 0) first_win = cyc + 1;
        end
        if (mcol == X-1) begin
          mcol = 0;
          mrow = (mrow == Y-1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
      end
      if (o_valid && lat_arm && first_ov < 0) first_ov = cyc;
      if (o_valid && o_ready) begin
        outs++;
        if (q.size() == 0) begin
          check("spurious_output", 64'(o_valid), 64'd0);
        end else begin
          e = q.pop_front();
          check("fmap", 64'(o_fmap), 64'(e.fmap));
          check("last", 64'(o_last), 64'(e.last));
          if (o_last) lasts++;
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_out   = {o_valid, o_last, o_fmap};
    end
  end

  task automatic set_cfg(input bit rnd_w, input int wv, input int b0, input int b1);
    for (int co = 0; co < NCO; co++)
      for (int ci = 0; ci < NCI; ci++)
        for (int ky = 0; ky < KK; ky++)
          for (int kx = 0; kx < KK; kx++) begin
            wt[co][ci][ky][kx] = rnd_w ? int'($urandom_range(255)) - 128 : wv;
            i_weight[(((co*NCI+ci)*KK+ky)*KK+kx)*WB +: WB] = WB'(wt[co][ci][ky][kx]);
          end
    bs[0] = b0;
    bs[1] = b1;
    i_bias[0 +: BB]  = BB'(b0);
    i_bias[BB +: BB] = BB'(b1);
  endtask

  task automatic setpix(input int mode, input int idx);
    int val;
    for (int ci = 0; ci < NCI; ci++) begin
      case (mode)
        0:       val = 1;
        1:       val = (idx % (X*Y)) * (ci + 1);
        2:       val = -1;
        3:       val = 1000;
        default: val = int'($urandom_range(6)) - 3;
      endcase
      i_fmap[ci*IB +: IB] = IB'(val);
    end
  endtask

  task automatic drive(input int mode, input int npix, input bit rnd_v);
    int  i = 0, guard = 0;
    bit  acc;
    setpix(mode, 0);
    while (i < npix && guard < 3000) begin
      i_valid = rnd_v ? ($urandom_range(3) != 0) : 1'b1;
      o_ready = rdy_rnd ? 1'($urandom_range(1)) : 1'b1;
      @(negedge clk);
      acc = i_valid && i_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        i++;
        if (i < npix) setpix(mode, i);
      end
    end
    i_valid = 1'b0;
    if (i < npix) check("drive_timeout", 64'(i), 64'(npix));
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 500) begin
      o_ready = rdy_rnd ? 1'($urandom_range(1)) : 1'b1;
      @(posedge clk);
      #1;
      guard++;
    end
    o_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic frame_counts(input string tag, input int n_out, input int n_last);
    check({tag, "_count"}, 64'(outs), 64'(n_out));
    check({tag, "_lasts"}, 64'(lasts), 64'(n_last));
    outs  = 0;
    lasts = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_ready", 64'(i_ready), 64'd1);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_fmap",  64'(o_fmap),  64'd0);
    check("rst_o_last",  64'(o_last),  64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // All ones: each output is 9 taps x 2 channels = 18, first 3 edges after 15th accept.
    set_cfg(1'b0, 1, 0, 0);
    lat_arm = 1'b1;
    drive(0, 36, 1'b0);
    drain();
    lat_arm = 1'b0;
    check("latency", 64'(first_ov - first_win), 64'd3);
    frame_counts("ones", 16, 1);

    // Ramp input exercises window alignment across row wraps.
    set_cfg(1'b0, 1, 5, -7);
    drive(1, 36, 1'b0);
    drain();
    frame_counts("ramp", 16, 1);

    // Negative sums: -18 - 100 = -118, or 0 with ReLU.
    set_cfg(1'b0, 1, -100, -100);
    drive(2, 36, 1'b0);
    drain();
    frame_counts("neg", 16, 1);

    // Saturation both ways.
    set_cfg(1'b0, 127, 0, 0);
    drive(3, 36, 1'b0);
    drain();
    frame_counts("sat_pos", 16, 1);
    set_cfg(1'b0, -128, 0, 0);
    drive(3, 36, 1'b0);
    drain();
    frame_counts("sat_neg", 16, 1);

    // Random weights/data with random input gaps and output backpressure, two frames.
    rdy_rnd = 1'b1;
    set_cfg(1'b1, 0, 37, -250);
    drive(4, 72, 1'b1);
    drain();
    rdy_rnd = 1'b0;
    frame_counts("bp", 32, 2);

    // Reset mid-frame, then a clean frame from (0,0).
    set_cfg(1'b0, 1, 5, -7);
    drive(1, 20, 1'b0);
    reset_n = 1'b0;
    q.delete();
    mrow = 0;
    mcol = 0;
    outs = 0;
    lasts = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 36, 1'b0);
    drain();
    frame_counts("post_rst", 16, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cnn_conv_stream.md
# cnn_conv_stream

Parametrised streaming 2-D convolution core: consumes one raster-order pixel (all input channels) per accepted beat. It builds a K×K×CI window from internal line buffers and computes CO output channels per window position (multiply-accumulate, + bias, shift, optional ReLU, saturate). It sits between conv stages in the CNN pipeline. Unlike the fixed-size stage cores, it is generic in size, channels and kernel, and supports full valid/ready backpressure and an end-of-frame flag.

## Interface
- IN_X, 12: input frame width (pixels)
- IN_Y, 12: input frame height (rows)
- K, 5: square kernel size, 1 ≤ K ≤ min(IN_X, IN_Y)
- CI, 3: input channels
- CO, 3: output channels
- IBW, 20: signed input sample width
- WBW, 8: signed weight width
- BBW, 16: signed bias width
- OSHIFT, 0: arithmetic right shift applied after bias add
- OBW, 32: signed output sample width
- clk  in  1  clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- i_weight  in  CO*CI*K*K*WBW  weights; element (co,ci,ky,kx) at bit offset (((co*CI+ci)*K+ky)*K+kx)*WBW; quasi-static, changed only while idle
- i_bias  in  CO*BBW  bias; channel co at co*BBW
- i_valid  in  1  input pixel valid
- i_ready  out  1  core can accept a pixel
- i_fmap  in  CI*IBW  input pixel; channel ci at ci*IBW
- o_valid  out  1  output pixel valid
- o_ready  in  1  downstream accepts
- o_fmap  out  CO*OBW  output pixel; channel co at co*OBW
- o_last  out  1  qualifies o_valid: last output pixel of frame

## Operation
- Accept = i_valid & i_ready. Column counter col (0..IN_X-1) and row counter row (0..IN_Y-1) advance on accept only. col wraps to 0 at IN_X-1 and increments row; row wraps to 0 after (IN_X-1, IN_Y-1). Counters wrap silently; there is no frame-start input.
- Line buffer: per channel, K-1 stored rows of IN_X samples plus the incoming pixel. On accept, column col shifts up one row, and the new sample enters the bottom row.
- Window on accept: ky=K-1 is the current row, ky=0 is the oldest row; kx=K-1 is the current column, kx=0 is col-(K-1). A window is produced iff row ≥ K-1 and col ≥ K-1 (no padding, stride 1). This gives (IN_X-K+1)×(IN_Y-K+1) outputs per frame, in raster order.
- Per output channel: acc = Σ over ci,ky,kx of window×weight. Full signed precision ACC_BW = IBW+WBW+clog2(CI*K*K).
- Post-processing: acc is sign-extended, bias is added, then >>> OSHIFT is applied. Activation follows (see Configuration). The result is saturated to OBW signed range.
- o_last is set on the output whose window ended at (row IN_Y-1, col IN_X-1).

## Timing
- Three-stage pipeline: S1 window register, S2 accumulation register, S3 bias/shift/act/saturate register driving o_fmap/o_valid/o_last.
- Latency: o_valid rises exactly 3 cycles after the accepting edge when no stall occurs.
- Global enable ce = !(o_valid & !o_ready). When ce=0, all stages, counters and line buffers hold. i_ready = ce (combinational from o_valid, o_ready).
- With o_ready held high, the core sustains 1 pixel/cycle input and 1 output/cycle.
- o_valid/o_fmap/o_last stay stable while o_valid & !o_ready.
- Bubbles (i_valid=0, or non-window positions) propagate as invalid stage slots; they do not stall.
- Reset values: i_ready 1, o_valid 0, o_fmap 0, o_last 0. Counters, line buffers and all stage valids are 0.
- reset_n asserted mid-frame: in-flight results are discarded. The next accepted pixel after release is treated as (row 0, col 0).
- i_weight/i_bias are sampled at S2/S3 respectively. Changing them with a window in flight is undefined.

## Configuration
- CNN_CONV_STREAM_RELU_EN defined: after shift, negative values become 0, and positive values saturate to 2^(OBW-1)-1.
- Undefined: no activation. Values saturate symmetrically to [-2^(OBW-1), 2^(OBW-1)-1].

## Test plan
- IN_X=IN_Y=6, K=3, CI=CO=1, all weights 1, bias 0, input all 1, o_ready=1 → 16 outputs each 9. First output appears 3 cycles after the 15th accept. o_last occurs only on the 16th output.
- Same config, input value = row*6+col, weights 1, bias 5 → output(r,c) = 9*(6(r+1)+(c+1))+5. This checks window alignment, including the first window of each row after wrap.
- Defaults, weights 1, bias −100, all inputs −1, RELU_EN defined → all outputs 0. With RELU_EN undefined → −175.
- o_ready toggled 1/0 on a random pattern with continuous i_valid → i_ready=0 exactly while o_valid & !o_ready. No output is lost or duplicated, and the sequence matches the golden model.
- OBW=8, inputs 1000, weights 127, bias 0 → output 127. With RELU_EN undefined and weights −128 → output −128 (saturation).
- reset_n pulsed low mid-frame (after 20 accepts) → o_valid 0 during reset. The next full frame yields a correct count and correct values, with o_last on the final output.
